// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath and hazard_stall_ctrl.
// master: pipeline side (drives hazard/handshake inputs, consumes controls).
// slave : hazard_stall_ctrl side.
interface hazard_stall_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic             ID_EX_MemRead_i;
  logic [REG_W-1:0] ID_EX_Rt_i;
  logic [REG_W-1:0] IF_ID_Rs_i;
  logic [REG_W-1:0] IF_ID_Rt_i;
  logic             branch_taken_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             PC_write_o;
  logic             IF_ID_write_o;
  logic             IF_ID_flush_o;
  logic             ID_EX_bubble_o;
  logic             freeze_o;
  logic             timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] wait_cnt_o;

  modport master (
    output ID_EX_MemRead_i, ID_EX_Rt_i, IF_ID_Rs_i, IF_ID_Rt_i,
           branch_taken_i, dmem_req_i, dmem_ack_i,
    input  PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
           freeze_o, timeout_o, stall_cnt_o, wait_cnt_o
  );

  modport slave (
    input  ID_EX_MemRead_i, ID_EX_Rt_i, IF_ID_Rs_i, IF_ID_Rt_i,
           branch_taken_i, dmem_req_i, dmem_ack_i,
    output PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
           freeze_o, timeout_o, stall_cnt_o, wait_cnt_o
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Arbitrates memory-wait freeze, load-use bubble and taken-branch flush
// (in that priority) and aborts memory waits after MEM_TIMEOUT cycles.
// Optional stall/wait performance counters: define HAZARD_STALL_PERF_EN.
module hazard_stall_ctrl #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  hazard_stall_ctrl_if.slave  bus
);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;

  logic load_use;
  logic mem_stall;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble;

  // Hazard detection and priority arbitration (combinational, zero latency)
  always_comb begin
    load_use = bus.ID_EX_MemRead_i && (bus.ID_EX_Rt_i != REG_W'(0)) &&
               ((bus.ID_EX_Rt_i == bus.IF_ID_Rs_i) || (bus.ID_EX_Rt_i == bus.IF_ID_Rt_i));
    mem_stall = (state_q == MEM_WAIT) ? !bus.dmem_ack_i
                                      : (bus.dmem_req_i && !bus.dmem_ack_i);
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (bus.branch_taken_i) begin
      if_id_flush = 1'b1;
    end
  end

  assign bus.PC_write_o     = pc_write;
  assign bus.IF_ID_write_o  = if_id_write;
  assign bus.IF_ID_flush_o  = if_id_flush;
  assign bus.ID_EX_bubble_o = id_ex_bubble;
  assign bus.freeze_o       = mem_stall;
  assign bus.timeout_o      = timeout_q;

  // Memory-wait state machine next-state, wait counter and sticky timeout
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    unique case (state_q)
      RUN: begin
        if (bus.dmem_req_i && !bus.dmem_ack_i) begin
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ack_i) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = RUN;
          wait_d    = '0;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef HAZARD_STALL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;

  // Saturating counters of bubble cycles and frozen cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (id_ex_bubble && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (mem_stall    && (wait_cnt_q  != '1)) wait_cnt_d  = wait_cnt_q  + CNT_W'(1);
  end

  // Counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.wait_cnt_o  = wait_cnt_q;
`else
  assign bus.stall_cnt_o = CNT_W'(0);
  assign bus.wait_cnt_o  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (MEM_TIMEOUT=4).
module tb_hazard_stall_ctrl;
  localparam int TMO = 4;
  localparam longint CNT_MAX = 65535;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();

  hazard_stall_ctrl #(.REG_W(5), .MEM_TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  // Stimulus currently applied
  bit       s_mr, s_br, s_req, s_ack;
  bit [4:0] s_exrt, s_rs, s_rt;

  // Reference model: length of the current frozen run, sticky timeout, counters
  int     frozen_len;
  bit     m_timeout;
  longint m_stall_cnt, m_wait_cnt;
  bit     e_freeze, e_bubble;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input bit mr, input bit [4:0] exrt, input bit [4:0] rs,
                       input bit [4:0] rt, input bit br, input bit req, input bit ack);
    s_mr = mr; s_exrt = exrt; s_rs = rs; s_rt = rt; s_br = br; s_req = req; s_ack = ack;
    bus.ID_EX_MemRead_i = mr;
    bus.ID_EX_Rt_i      = exrt;
    bus.IF_ID_Rs_i      = rs;
    bus.IF_ID_Rt_i      = rt;
    bus.branch_taken_i  = br;
    bus.dmem_req_i      = req;
    bus.dmem_ack_i      = ack;
  endtask

  // Compare every output against the rules, then advance the model by one edge
  task automatic check_and_advance(input string tag);
    bit lu;
    e_freeze = (frozen_len > 0) ? !s_ack : (s_req && !s_ack);
    lu       = s_mr && (s_exrt != 0) && ((s_exrt == s_rs) || (s_exrt == s_rt));
    e_bubble = !e_freeze && lu;
    chk({tag, ".freeze"},  32'(bus.freeze_o),       32'(e_freeze));
    chk({tag, ".pcw"},     32'(bus.PC_write_o),     32'(!e_freeze && !lu));
    chk({tag, ".ifidw"},   32'(bus.IF_ID_write_o),  32'(!e_freeze && !lu));
    chk({tag, ".bubble"},  32'(bus.ID_EX_bubble_o), 32'(e_bubble));
    chk({tag, ".flush"},   32'(bus.IF_ID_flush_o),  32'(!e_freeze && !lu && s_br));
    chk({tag, ".timeout"}, 32'(bus.timeout_o),      32'(m_timeout));
`ifdef HAZARD_STALL_PERF_EN
    chk({tag, ".stallcnt"}, 32'(bus.stall_cnt_o), 32'(m_stall_cnt));
    chk({tag, ".waitcnt"},  32'(bus.wait_cnt_o),  32'(m_wait_cnt));
`else
    chk({tag, ".stallcnt"}, 32'(bus.stall_cnt_o), 32'd0);
    chk({tag, ".waitcnt"},  32'(bus.wait_cnt_o),  32'd0);
`endif
    if (e_bubble && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    if (e_freeze) begin
      if (m_wait_cnt < CNT_MAX) m_wait_cnt++;
      frozen_len++;
      if (frozen_len == TMO) begin
        m_timeout  = 1'b1;
        frozen_len = 0;
      end
    end else begin
      frozen_len = 0;
    end
  endtask

  task automatic step(input string tag, input bit mr, input bit [4:0] exrt, input bit [4:0] rs,
                      input bit [4:0] rt, input bit br, input bit req, input bit ack);
    @(negedge clk_i);
    apply(mr, exrt, rs, rt, br, req, ack);
    #2;
    check_and_advance(tag);
  endtask

  // Asynchronous reset pulse entirely between clock edges
  task automatic do_reset(input string tag);
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0);
    frozen_len = 0; m_timeout = 0; m_stall_cnt = 0; m_wait_cnt = 0;
    #1;
    check_and_advance(tag);
    #1;
    rst_i = 1'b0;
  endtask

  int frz;

  initial begin
    apply(0, 0, 0, 0, 0, 0, 0);
    frozen_len = 0; m_timeout = 0; m_stall_cnt = 0; m_wait_cnt = 0;

    do_reset("reset");
    chk("reset.pcw_const", 32'(bus.PC_write_o), 32'd1);

    // Load-use: one bubble cycle, then the bubble has cleared MemRead
    step("lu", 1, 5, 5, 0, 0, 0, 0);
    chk("lu.bubble_const", 32'(bus.ID_EX_bubble_o), 32'd1);
    step("lu_after", 0, 5, 5, 0, 0, 0, 0);
    step("lu_rt_match", 1, 7, 1, 7, 0, 0, 0);
    step("lu_r0", 1, 0, 0, 0, 0, 0, 0);
    chk("lu_r0.pcw_const", 32'(bus.PC_write_o), 32'd1);

    // Branch alone, then branch colliding with load-use
    step("br", 0, 0, 0, 0, 1, 0, 0);
    chk("br.flush_const", 32'(bus.IF_ID_flush_o), 32'd1);
    step("br_after", 0, 0, 0, 0, 0, 0, 0);
    step("br_lu", 1, 3, 3, 0, 1, 0, 0);
    chk("br_lu.flush_const", 32'(bus.IF_ID_flush_o), 32'd0);
    step("br_retry", 0, 3, 3, 0, 1, 0, 0);
    chk("br_retry.flush_const", 32'(bus.IF_ID_flush_o), 32'd1);

    // Memory wait: ack three cycles after the request
    do_reset("reset2");
    frz = 0;
    step("mw0", 0, 0, 0, 0, 0, 1, 0); frz += int'(bus.freeze_o);
    step("mw1", 0, 0, 0, 0, 0, 1, 0); frz += int'(bus.freeze_o);
    step("mw2", 1, 2, 2, 0, 1, 1, 0); frz += int'(bus.freeze_o);
    step("mw_ack", 0, 0, 0, 0, 0, 1, 1); frz += int'(bus.freeze_o);
    chk("mw.frozen_cycles", 32'(frz), 32'd3);
    step("mw_idle", 0, 0, 0, 0, 0, 0, 0);
    step("mw_ack_norq", 0, 0, 0, 0, 0, 0, 1);
    step("mw_same_ack", 0, 0, 0, 0, 0, 1, 1);
`ifdef HAZARD_STALL_PERF_EN
    chk("mw.waitcnt_const", 32'(bus.wait_cnt_o), 32'd3);
`endif

    // Timeout: request held without ack
    for (int i = 0; i < TMO; i++) step("to_wait", 0, 0, 0, 0, 0, 1, 0);
    step("to_retry", 0, 0, 0, 0, 0, 1, 0);
    chk("to.timeout_const", 32'(bus.timeout_o), 32'd1);
    chk("to.refreeze_const", 32'(bus.freeze_o), 32'd1);
    step("to_release", 0, 0, 0, 0, 0, 0, 1);
    step("to_sticky", 0, 0, 0, 0, 0, 0, 0);
    chk("to.sticky_const", 32'(bus.timeout_o), 32'd1);

    // Reset in the middle of a wait
    step("rw0", 0, 0, 0, 0, 0, 1, 0);
    step("rw1", 0, 0, 0, 0, 0, 1, 0);
    do_reset("rw_rst");
    step("rw_after", 0, 0, 0, 0, 0, 0, 0);
    chk("rw.pcw_const", 32'(bus.PC_write_o), 32'd1);
    chk("rw.freeze_const", 32'(bus.freeze_o), 32'd0);
    chk("rw.timeout_const", 32'(bus.timeout_o), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd",
             1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             $urandom_range(0, 9) < 4,
             $urandom_range(0, 9) < 3);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Decides per cycle whether PC / IF_ID / ID_EX advance, hold, bubble or flush, based on:
  - load-use hazards,
  - taken branches,
  - a variable-latency data-memory handshake.
- Sits beside Control: its bubble output zeroes the 8-bit ID_EX control word that Control produces. Its freeze output holds every pipeline register during memory waits.

Parameters:
- REG_W, 5, register specifier width.
- MEM_TIMEOUT, 16, max cycles to wait for dmem_ack_i before abort (legal range 2..255).
- CNT_W, 16, width of the stall counters (optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ID_EX_MemRead_i  in  1  instruction in EX is a load.
- ID_EX_Rt_i  in  REG_W  destination of the load in EX.
- IF_ID_Rs_i  in  REG_W  Rs of the instruction in ID.
- IF_ID_Rt_i  in  REG_W  Rt of the instruction in ID.
- branch_taken_i  in  1  beq in ID resolved taken (Control branch_o AND equal).
- dmem_req_i  in  1  MEM stage issues a data-memory access this cycle.
- dmem_ack_i  in  1  data memory completes the access.
- PC_write_o  out  1  PC may load next value.
- IF_ID_write_o  out  1  IF_ID may load.
- IF_ID_flush_o  out  1  IF_ID loads a nop.
- ID_EX_bubble_o  out  1  ID_EX control word forced to 8'b0.
- freeze_o  out  1  all pipeline registers (PC through MEM_WB) hold.
- timeout_o  out  1  sticky memory-timeout flag.
- stall_cnt_o  out  CNT_W  load-use stall cycles (optional feature).
- wait_cnt_o  out  CNT_W  memory-wait cycles (optional feature).

Behaviour:
- States: RUN, MEM_WAIT. Reset (async, rst_i=1):
  - state=RUN, internal wait counter=0, timeout_o=0, counters=0.
  - Combinational outputs take their RUN values with all inputs 0: PC_write_o=1, IF_ID_write_o=1, others 0.
- load_use = ID_EX_MemRead_i && ID_EX_Rt_i!=0 && (ID_EX_Rt_i==IF_ID_Rs_i || ID_EX_Rt_i==IF_ID_Rt_i).
- mem_stall = dmem_req_i && !dmem_ack_i (RUN), or !dmem_ack_i (MEM_WAIT).
- Priority, highest first: mem_stall, then load_use, then branch_taken_i.
- mem_stall: freeze_o=1, PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=0, IF_ID_flush_o=0. Pending hazards are re-evaluated after release.
- load_use, no mem_stall:
  - PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1, IF_ID_flush_o=0.
  - Exactly 1 stall cycle, because the bubble clears ID_EX_MemRead_i next cycle.
  - A simultaneous branch_taken_i is ignored and re-presented next cycle.
- branch_taken_i alone: IF_ID_flush_o=1, PC_write_o=1, IF_ID_write_o=1.
- All outputs except timeout_o and the counters are combinational from state and inputs, with zero latency.
- Transitions:
  - RUN -> MEM_WAIT when dmem_req_i && !dmem_ack_i; wait counter loads 1.
  - Request with same-cycle ack causes no stall.
  - MEM_WAIT -> RUN on dmem_ack_i. freeze_o drops in the ack cycle and the pipeline advances on that edge.
  - MEM_WAIT with !dmem_ack_i and wait counter == MEM_TIMEOUT-1:
    - timeout_o<=1 (sticky until reset), go to RUN, wait counter<=0.
    - freeze_o stays 1 in that cycle and deasserts the next cycle.
    - If dmem_req_i is still high in RUN, a new wait begins.
  - Otherwise in MEM_WAIT, the wait counter increments.
- Ack arriving in RUN without a request: ignored.
- rst_i mid-MEM_WAIT: immediate return to RUN, all state cleared.

Optional Feature:
- Macro HAZARD_STALL_PERF_EN.
- Defined:
  - stall_cnt_o increments each cycle ID_EX_bubble_o=1.
  - wait_cnt_o increments each cycle freeze_o=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: both outputs tied to 0 and no counter flops are built.
- Behaviour of all other outputs is identical either way.

Test Plan:
- Reset mid-wait: rst_i pulsed while in MEM_WAIT -> next cycle PC_write_o=1, freeze_o=0, timeout_o=0.
- Load-use: ID_EX_MemRead_i=1, ID_EX_Rt_i=5, IF_ID_Rs_i=5 -> one cycle with PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1. With ID_EX_Rt_i=0, no stall.
- Branch flush and collision with load-use:
  - branch_taken_i=1 alone -> IF_ID_flush_o=1 for that cycle only, PC_write_o=1.
  - Same cycle as load-use -> flush=0, bubble=1. The branch held in ID then flushes the following cycle.
- Memory wait: dmem_req_i=1, ack returned 3 cycles later -> freeze_o=1 for exactly 3 cycles, 0 in the ack cycle. Under HAZARD_STALL_PERF_EN, wait_cnt_o=3.
- Timeout: MEM_TIMEOUT=4, dmem_req_i held high, no ack -> timeout_o rises after 4 frozen cycles and stays 1; freeze re-asserts on the retry.
